// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer game: state encoding
// and default timing constants used by the controller and display path.
package reaction_pkg;

    localparam int RDM_W_DEF     = 10;
    localparam int RES_W_DEF     = 16;
    localparam int MIN_DELAY_DEF = 50;
    localparam int GO_HOLD_DEF   = 200;
    localparam int TIMEOUT_DEF   = 9999;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WAIT = 3'd1;
    localparam state_t ST_GO   = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_FOUL = 3'd4;

endpackage

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the reaction-timer game: random pre-delay,
// GO indication, reaction measurement, foul/timeout and best time.
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int RDM_W     = RDM_W_DEF,
    parameter int RES_W     = RES_W_DEF,
    parameter int MIN_DELAY = MIN_DELAY_DEF,
    parameter int GO_HOLD   = GO_HOLD_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk100hz,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [RDM_W-1:0] rnd,
    output logic             go_led,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             foul,
    output logic             timeout,
    output logic [RES_W-1:0] best,
    output logic             busy
);

    localparam int DW = RDM_W + 1;

    state_t           state;
    logic [DW-1:0]    dly;
    logic [RES_W-1:0] rcnt;
    logic [RES_W-1:0] rcnt_inc;

    assign rcnt_inc = rcnt + 1'b1;
    assign busy     = (state == ST_WAIT) || (state == ST_GO);

    always_ff @(posedge clk100hz) begin
        if (rst) begin
            state        <= ST_IDLE;
            dly          <= '0;
            rcnt         <= '0;
            go_led       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
            best         <= '1;
        end else if (start) begin
            state        <= ST_WAIT;
            dly          <= DW'(MIN_DELAY) + DW'(rnd);
            go_led       <= 1'b0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    // stop wins over the WAIT->GO step
                    if (stop) begin
                        state <= ST_FOUL;
                        foul  <= 1'b1;
                    end else if (dly <= DW'(1)) begin
                        state  <= ST_GO;
                        go_led <= 1'b1;
                        rcnt   <= '0;
                    end else begin
                        dly <= dly - 1'b1;
                    end
                end
                ST_GO: begin
                    if (stop) begin
                        state        <= ST_DONE;
                        result       <= rcnt;
                        result_valid <= 1'b1;
                        go_led       <= 1'b0;
                        if (rcnt < best) best <= rcnt;
                    end else if (rcnt == RES_W'(TIMEOUT - 1)) begin
                        state        <= ST_DONE;
                        result       <= RES_W'(TIMEOUT);
                        timeout      <= 1'b1;
                        result_valid <= 1'b0;
                        go_led       <= 1'b0;
                    end else begin
                        rcnt <= rcnt_inc;
                        if (rcnt_inc >= RES_W'(GO_HOLD)) go_led <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
